// File: rtl/elink_pkg.sv
// Shared constants for the E-link TX scheduler: delimiter codes, FSM
// state encoding and the idle/comma word handed to the 8b10b encoder.
package elink_pkg;

    localparam logic [1:0] DELIM_DATA  = 2'b00;
    localparam logic [1:0] DELIM_SOP   = 2'b10;
    localparam logic [1:0] DELIM_EOP   = 2'b01;
    localparam logic [1:0] DELIM_COMMA = 2'b11;

    // Idle word: comma delimiter with a zero byte field.
    localparam logic [9:0] COMMA_WORD  = {DELIM_COMMA, 8'h00};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_EOP  = 2'd2
    } state_t;

endpackage

// File: rtl/elink_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after
// the pointer, wrapping around. Returns one-hot grant plus its index.
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int IW   = 2
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [N_CH-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);

    int   c;
    logic found;

    // Scan N_CH positions starting at the pointer; first hit wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found   = 1'b0;
        c       = 0;
        for (int k = 0; k < N_CH; k++) begin
            c = int'(ptr_i) + k;
            if (c >= N_CH) c = c - N_CH;
            if (!found && req_i[c]) begin
                found    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = IW'(c);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/elink_tx_scheduler.sv
// Round-robin frame scheduler feeding the E-link 8b10b TX encoder from
// N_CH FWFT byte FIFOs. One 10-bit word {delim, byte} per encoder request.
module elink_tx_scheduler
    import elink_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int MAX_FRAME = 16,
    parameter int MAX_GAP   = 8
) (
    input  logic              bitCLKx4,
    input  logic              rst,
    input  logic              enable,
    input  logic              getDataTrig,
    output logic [9:0]        EDATA_OUT,
    output logic              EDATA_RDY,
    input  logic [N_CH-1:0]   fifo_empty_i,
    input  logic [9*N_CH-1:0] fifo_dout_i,
    output logic [N_CH-1:0]   fifo_rd_o,
    output logic [N_CH-1:0]   grant_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              underrun_err_o,
    output logic              overlen_err_o
);

    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CW = $clog2(MAX_FRAME + 1);
    localparam int GW = $clog2(MAX_GAP + 1);

    state_t            state_q;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     gidx_q;
    logic [CW-1:0]     cnt_q;
    logic [GW-1:0]     gap_q;
    logic              uflag_q;
    logic              oflag_q;
    logic [9:0]        word_q;
    logic              rdy_q;
    logic [N_CH-1:0]   rd_q;
    logic [N_CH-1:0]   grant_q;
    logic              busy_q;
    logic              done_q;
    logic              uerr_q;
    logic              oerr_q;

    logic [N_CH-1:0]   arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic              arb_vld;
    logic [8:0]        head;
    logic              head_empty;
    logic              accept;
    logic [IW-1:0]     ptr_next;

    rr_arbiter #(.N_CH(N_CH), .IW(IW)) u_arb (
        .req_i   (~fifo_empty_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_vld)
    );

    // Requests landing on the strobe cycle are dropped, so each accepted
    // request maps to exactly one strobe.
    assign accept     = getDataTrig & ~rdy_q;
    assign head       = fifo_dout_i[gidx_q*9 +: 9];
    assign head_empty = fifo_empty_i[gidx_q];
    assign ptr_next   = (gidx_q == IW'(N_CH - 1)) ? '0 : gidx_q + 1'b1;

    // Frame FSM; all outputs registered, advanced only on accepted requests.
    always_ff @(posedge bitCLKx4 or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            uflag_q <= 1'b0;
            oflag_q <= 1'b0;
            word_q  <= COMMA_WORD;
            rdy_q   <= 1'b0;
            rd_q    <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            uerr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            rdy_q  <= 1'b0;
            rd_q   <= '0;
            done_q <= 1'b0;
            uerr_q <= 1'b0;
            oerr_q <= 1'b0;
            // Grant stays visible through the EOP strobe, drops right after.
            if (done_q) begin
                grant_q <= '0;
                busy_q  <= 1'b0;
            end
            if (accept) begin
                rdy_q <= 1'b1;
                case (state_q)
                    ST_IDLE: begin
                        if (enable && arb_vld) begin
                            word_q  <= {DELIM_SOP, 8'h00};
                            grant_q <= arb_gnt;
                            gidx_q  <= arb_idx;
                            busy_q  <= 1'b1;
                            state_q <= ST_DATA;
                        end else begin
                            word_q  <= COMMA_WORD;
                        end
                    end
                    ST_DATA: begin
                        if (!head_empty) begin
                            word_q <= {DELIM_DATA, head[7:0]};
                            rd_q   <= grant_q;
                            cnt_q  <= cnt_q + 1'b1;
                            gap_q  <= '0;
                            // An explicit last byte takes precedence over truncation.
                            if (head[8]) begin
                                state_q <= ST_EOP;
                            end else if (cnt_q == CW'(MAX_FRAME - 1)) begin
                                state_q <= ST_EOP;
                                oflag_q <= 1'b1;
                            end
                        end else begin
                            word_q <= COMMA_WORD;
                            gap_q  <= gap_q + 1'b1;
                            if (gap_q == GW'(MAX_GAP - 1)) begin
                                state_q <= ST_EOP;
                                uflag_q <= 1'b1;
                            end
                        end
                    end
                    ST_EOP: begin
                        word_q  <= {DELIM_EOP, 8'h00};
                        done_q  <= 1'b1;
                        uerr_q  <= uflag_q;
                        oerr_q  <= oflag_q;
                        uflag_q <= 1'b0;
                        oflag_q <= 1'b0;
                        cnt_q   <= '0;
                        gap_q   <= '0;
                        ptr_q   <= ptr_next;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign EDATA_OUT      = word_q;
    assign EDATA_RDY      = rdy_q;
    assign fifo_rd_o      = rd_q;
    assign grant_o        = grant_q;
    assign busy_o         = busy_q;
    assign frame_done_o   = done_q;
    assign underrun_err_o = uerr_q;
    assign overlen_err_o  = oerr_q;

endmodule

// File: tb/tb_elink_tx_scheduler.sv
// Scoreboard bench: stimulus pushes the expected word per request, a
// monitor pops and compares on every EDATA_RDY strobe.
module tb_elink_tx_scheduler;

    localparam int N = 4;

    logic           bitCLKx4 = 1'b0;
    logic           rst = 1'b0;
    logic           enable = 1'b0;
    logic           getDataTrig = 1'b0;
    logic [9:0]     EDATA_OUT;
    logic           EDATA_RDY;
    logic [N-1:0]   fifo_empty_i;
    logic [9*N-1:0] fifo_dout_i;
    logic [N-1:0]   fifo_rd_o;
    logic [N-1:0]   grant_o;
    logic           busy_o;
    logic           frame_done_o;
    logic           underrun_err_o;
    logic           overlen_err_o;

    always #5 bitCLKx4 = ~bitCLKx4;

    elink_tx_scheduler #(.N_CH(N), .MAX_FRAME(16), .MAX_GAP(8)) dut (
        .bitCLKx4       (bitCLKx4),
        .rst            (rst),
        .enable         (enable),
        .getDataTrig    (getDataTrig),
        .EDATA_OUT      (EDATA_OUT),
        .EDATA_RDY      (EDATA_RDY),
        .fifo_empty_i   (fifo_empty_i),
        .fifo_dout_i    (fifo_dout_i),
        .fifo_rd_o      (fifo_rd_o),
        .grant_o        (grant_o),
        .busy_o         (busy_o),
        .frame_done_o   (frame_done_o),
        .underrun_err_o (underrun_err_o),
        .overlen_err_o  (overlen_err_o)
    );

    // FWFT FIFO model per channel: initial block writes, monitor pops.
    logic [8:0] mem [N][32];
    int         wptr [N];
    int         rptr [N];

    for (genvar c = 0; c < N; c++) begin : g_fifo
        assign fifo_empty_i[c]         = (rptr[c] == wptr[c]);
        assign fifo_dout_i[9*c +: 9]   = mem[c][rptr[c] % 32];
    end

    always @(posedge bitCLKx4) begin
        for (int c = 0; c < N; c++)
            if (fifo_rd_o[c]) rptr[c] = rptr[c] + 1;
    end

    typedef struct packed {
        logic [9:0] w;
        logic [3:0] g;
        logic [3:0] rd;
        logic       done;
        logic       ue;
        logic       oe;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    logic acc = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Latency reference: an accepted request must strobe on the next cycle.
    always @(posedge bitCLKx4) acc = getDataTrig && !EDATA_RDY && rst;

    // Monitor: compare each strobe to the scoreboard, police quiet cycles.
    always @(negedge bitCLKx4) begin
        exp_t e;
        if (acc || EDATA_RDY) chk("rdy_latency", 32'(EDATA_RDY), 32'(acc));
        if (EDATA_RDY) begin
            if (q.size() == 0) begin
                chk("unexpected_word", 32'(EDATA_OUT), 32'h3ff);
            end else begin
                e = q.pop_front();
                chk("word",  32'(EDATA_OUT),      32'(e.w));
                chk("grant", 32'(grant_o),        32'(e.g));
                chk("busy",  32'(busy_o),         32'(e.g != 0));
                chk("rd",    32'(fifo_rd_o),      32'(e.rd));
                chk("done",  32'(frame_done_o),   32'(e.done));
                chk("uerr",  32'(underrun_err_o), 32'(e.ue));
                chk("oerr",  32'(overlen_err_o),  32'(e.oe));
            end
        end else if (rst) begin
            if (fifo_rd_o != 0 || frame_done_o || underrun_err_o || overlen_err_o)
                chk("quiet_pulses", {fifo_rd_o, frame_done_o, underrun_err_o, overlen_err_o}, 32'h0);
        end
    end

    task automatic push(input int ch, input logic [8:0] v);
        mem[ch][wptr[ch] % 32] = v;
        wptr[ch] = wptr[ch] + 1;
    endtask

    task automatic send(input logic [9:0] w, input logic [3:0] g, input logic [3:0] rd,
                        input logic done, input logic ue, input logic oe);
        exp_t e;
        e = '{w: w, g: g, rd: rd, done: done, ue: ue, oe: oe};
        q.push_back(e);
        @(negedge bitCLKx4) getDataTrig = 1'b1;
        @(negedge bitCLKx4) getDataTrig = 1'b0;
        repeat (2) @(negedge bitCLKx4);
    endtask

    task automatic do_reset();
        @(negedge bitCLKx4) rst = 1'b0;
        #1;
        chk("rst_word",  32'(EDATA_OUT), 32'h300);
        chk("rst_rdy",   32'(EDATA_RDY), 32'h0);
        chk("rst_grant", 32'(grant_o),   32'h0);
        chk("rst_busy",  32'(busy_o),    32'h0);
        chk("rst_pulse", {fifo_rd_o, frame_done_o, underrun_err_o, overlen_err_o}, 32'h0);
        repeat (2) @(negedge bitCLKx4);
        rst = 1'b1;
        repeat (2) @(negedge bitCLKx4);
    endtask

    initial begin
        for (int c = 0; c < N; c++) begin
            wptr[c] = 0;
            rptr[c] = 0;
            for (int j = 0; j < 32; j++) mem[c][j] = '0;
        end
        do_reset();
        enable = 1'b1;

        // Idle: all FIFOs empty -> commas only.
        for (int i = 0; i < 5; i++) send(10'h300, 4'b0000, 4'b0000, 0, 0, 0);

        // Single frame on ch1.
        push(1, 9'h0A5); push(1, 9'h03C); push(1, 9'h17E);
        send(10'h200, 4'b0010, 4'b0000, 0, 0, 0);
        send(10'h0A5, 4'b0010, 4'b0010, 0, 0, 0);
        send(10'h03C, 4'b0010, 4'b0010, 0, 0, 0);
        send(10'h07E, 4'b0010, 4'b0010, 0, 0, 0);
        send(10'h100, 4'b0010, 4'b0000, 1, 0, 0);
        send(10'h300, 4'b0000, 4'b0000, 0, 0, 0);

        // Round-robin from pointer 0: ch0, ch2, then ch0's second frame.
        do_reset();
        push(0, 9'h111); push(0, 9'h133); push(2, 9'h122);
        send(10'h200, 4'b0001, 4'b0000, 0, 0, 0);
        send(10'h011, 4'b0001, 4'b0001, 0, 0, 0);
        send(10'h100, 4'b0001, 4'b0000, 1, 0, 0);
        send(10'h200, 4'b0100, 4'b0000, 0, 0, 0);
        send(10'h022, 4'b0100, 4'b0100, 0, 0, 0);
        send(10'h100, 4'b0100, 4'b0000, 1, 0, 0);
        send(10'h200, 4'b0001, 4'b0000, 0, 0, 0);
        send(10'h033, 4'b0001, 4'b0001, 0, 0, 0);
        send(10'h100, 4'b0001, 4'b0000, 1, 0, 0);

        // Underrun on ch3: one byte, then 8 in-frame commas, then aborted EOP.
        push(3, 9'h055);
        send(10'h200, 4'b1000, 4'b0000, 0, 0, 0);
        send(10'h055, 4'b1000, 4'b1000, 0, 0, 0);
        for (int i = 0; i < 8; i++) send(10'h300, 4'b1000, 4'b0000, 0, 0, 0);
        send(10'h100, 4'b1000, 4'b0000, 1, 1, 0);

        // Over-length on ch0 (20 bytes, no last); ch1 waits its turn.
        for (int i = 0; i < 20; i++) push(0, {1'b0, 8'(i)});
        push(1, 9'h166);
        send(10'h200, 4'b0001, 4'b0000, 0, 0, 0);
        for (int i = 0; i < 16; i++) send({2'b00, 8'(i)}, 4'b0001, 4'b0001, 0, 0, 0);
        send(10'h100, 4'b0001, 4'b0000, 1, 0, 1);
        send(10'h200, 4'b0010, 4'b0000, 0, 0, 0);
        send(10'h066, 4'b0010, 4'b0010, 0, 0, 0);
        send(10'h100, 4'b0010, 4'b0000, 1, 0, 0);
        send(10'h200, 4'b0001, 4'b0000, 0, 0, 0);
        for (int i = 16; i < 20; i++) send({2'b00, 8'(i)}, 4'b0001, 4'b0001, 0, 0, 0);
        for (int i = 0; i < 8; i++) send(10'h300, 4'b0001, 4'b0000, 0, 0, 0);
        send(10'h100, 4'b0001, 4'b0000, 1, 1, 0);

        // Reset mid-frame on ch1; FIFO keeps its remaining byte.
        push(1, 9'h081); push(1, 9'h082); push(1, 9'h183);
        send(10'h200, 4'b0010, 4'b0000, 0, 0, 0);
        send(10'h081, 4'b0010, 4'b0010, 0, 0, 0);
        send(10'h082, 4'b0010, 4'b0010, 0, 0, 0);
        enable = 1'b0;
        do_reset();
        send(10'h300, 4'b0000, 4'b0000, 0, 0, 0);
        enable = 1'b1;
        send(10'h200, 4'b0010, 4'b0000, 0, 0, 0);
        send(10'h083, 4'b0010, 4'b0010, 0, 0, 0);
        send(10'h100, 4'b0010, 4'b0000, 1, 0, 0);
        send(10'h300, 4'b0000, 4'b0000, 0, 0, 0);

        repeat (5) @(negedge bitCLKx4);
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
